mem_arbiter: RTL and testbench

- Shares one single-port, fixed-latency RAM between the pipelined core's instruction-fetch port and its data port (ena_rd/ena_wr/alu_out_ext/dataram_wr).
- Data accesses have priority. A streak limiter prevents fetch starvation.
- Per-port stall outputs drive the core's PCWrite/IFIDWrite freeze logic, so the core holds each request stable until its valid pulse.

---
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port, fixed-latency RAM between instruction fetch and data access.
// Data wins ties unless it has already been granted MAX_STREAK times in a row while a fetch waits.
module mem_arbiter #(
  parameter int LAT        = 1,
  parameter int MAX_STREAK = 3
) (
  input  logic        CLOCK,
  input  logic        RST_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_stall,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_D, BUSY_I} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  streak_q, streak_d;
  logic        wr_q, wr_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        if_valid_q, if_valid_d;
  logic        d_valid_q, d_valid_d;

  logic d_elig, f_elig, grant_i, grant_d;

  // A port whose valid pulse is high this cycle has just been served; do not grant it again.
  assign d_elig  = (d_rd | d_wr) & ~d_valid_q;
  assign f_elig  = if_req & ~if_valid_q;
  assign grant_i = (state_q == IDLE) & f_elig & (~d_elig | (streak_q == 4'(MAX_STREAK)));
  assign grant_d = (state_q == IDLE) & d_elig & ~grant_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    wr_d        = wr_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d    = BUSY_I;
          cnt_d      = 3'd0;
          streak_d   = 4'd0;
          mem_en_d   = 1'b1;
          mem_addr_d = if_addr;
        end else if (grant_d) begin
          state_d     = BUSY_D;
          cnt_d       = 3'd0;
          wr_d        = d_wr;
          mem_en_d    = 1'b1;
          mem_we_d    = d_wr;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          // Only count data grants that actually made a fetch wait.
          if (!if_req)
            streak_d = 4'd0;
          else if (streak_q != 4'(MAX_STREAK))
            streak_d = streak_q + 4'd1;
        end
      end
      BUSY_D: begin
        if (cnt_q == 3'(LAT)) begin
          if (!wr_q) d_rdata_d = mem_rdata;
          d_valid_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      BUSY_I: begin
        if (cnt_q == 3'(LAT)) begin
          if_rdata_d = mem_rdata;
          if_valid_d = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      streak_q    <= 4'd0;
      wr_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      wr_q        <= wr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign if_stall  = if_req & ~if_valid_q;
  assign d_rdata   = d_rdata_q;
  assign d_valid   = d_valid_q;
  assign d_stall   = (d_rd | d_wr) & ~d_valid_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a LAT=1 instance and a LAT=2 instance share stimulus,
// each behind its own fixed-latency RAM model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_rd, d_wr;
  logic [31:0] if_addr, d_addr, d_wdata;

  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        if_valid1, if_stall1, d_valid1, d_stall1, mem_en1, mem_we1;
  logic [31:0] if_rdata2, d_rdata2, mem_addr2, mem_wdata2, mem_rdata2;
  logic        if_valid2, if_stall2, d_valid2, d_stall2, mem_en2, mem_we2;

  logic [31:0] ram1_p0, ram2_p0, ram2_p1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.LAT(1), .MAX_STREAK(3)) u_dut1 (
    .CLOCK(clk), .RST_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata1), .if_valid(if_valid1), .if_stall(if_stall1),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata1), .d_valid(d_valid1), .d_stall(d_stall1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  mem_arbiter #(.LAT(2), .MAX_STREAK(3)) u_dut2 (
    .CLOCK(clk), .RST_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata2), .if_valid(if_valid2), .if_stall(if_stall2),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata2), .d_valid(d_valid2), .d_stall(d_stall2),
    .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
  );

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return (a == 32'h40) ? 32'h0050_0093 : (a ^ 32'hA5A5_0000);
  endfunction

  // RAM models return a marker word whenever no read was issued LAT cycles ago.
  always @(posedge clk) begin
    ram1_p0 <= (mem_en1 && !mem_we1) ? ram_word(mem_addr1) : 32'hBAD0_BAD0;
    ram2_p0 <= (mem_en2 && !mem_we2) ? ram_word(mem_addr2) : 32'hBAD0_BAD0;
    ram2_p1 <= ram2_p0;
  end
  assign mem_rdata1 = ram1_p0;
  assign mem_rdata2 = ram2_p1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int         n_en, n_we, ng;
    logic       seen;
    logic [3:0] prev_streak;
    logic [7:0] got_f;

    rst_n = 1'b0;
    if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    tick();
    tick();
    chk("rst_mem_en",    mem_en2,    0);
    chk("rst_mem_we",    mem_we2,    0);
    chk("rst_mem_addr",  mem_addr2,  0);
    chk("rst_mem_wdata", mem_wdata2, 0);
    chk("rst_if_rdata",  if_rdata2,  0);
    chk("rst_d_rdata",   d_rdata2,   0);
    chk("rst_if_valid",  if_valid2,  0);
    chk("rst_d_valid",   d_valid2,   0);
    chk("rst_stalls",    {30'd0, if_stall2, d_stall2}, 0);
    chk("rst_lat1_en",   mem_en1,    0);

    // Fetch only, LAT=1
    rst_n = 1'b1;
    tick();
    if_req = 1'b1; if_addr = 32'h40;
    #1;
    chk("f1_stall_c0", if_stall1, 1);
    tick();
    chk("f1_mem_en_c1",   mem_en1,   1);
    chk("f1_mem_we_c1",   mem_we1,   0);
    chk("f1_mem_addr_c1", mem_addr1, 32'h40);
    chk("f1_stall_c1",    if_stall1, 1);
    chk("f1_valid_c1",    if_valid1, 0);
    tick();
    chk("f1_mem_en_c2", mem_en1,   0);
    chk("f1_stall_c2",  if_stall1, 1);
    chk("f1_valid_c2",  if_valid1, 0);
    tick();
    chk("f1_valid_c3",  if_valid1, 1);
    chk("f1_rdata_c3",  if_rdata1, 32'h0050_0093);
    chk("f1_stall_c3",  if_stall1, 0);
    chk("f1_mem_en_c3", mem_en1,   0);
    tick();
    if_req = 1'b0;
    chk("f1_no_regrant_c4", mem_en1,   0);
    chk("f1_valid_c4",      if_valid1, 0);

    // Collision, LAT=2: data first, fetch right after the data valid cycle
    do_reset();
    d_rd = 1'b1; d_addr = 32'h100; if_req = 1'b1; if_addr = 32'h40;
    tick();
    chk("col_d_en_c1",   mem_en2,   1);
    chk("col_d_addr_c1", mem_addr2, 32'h100);
    chk("col_d_we_c1",   mem_we2,   0);
    tick();
    tick();
    chk("col_d_valid_c3", d_valid2, 0);
    tick();
    chk("col_d_valid_c4", d_valid2, 1);
    chk("col_d_rdata_c4", d_rdata2, 32'hA5A5_0100);
    chk("col_en_c4",      mem_en2,  0);
    tick();
    d_rd = 1'b0;
    chk("col_i_en_c5",    mem_en2,   1);
    chk("col_i_addr_c5",  mem_addr2, 32'h40);
    chk("col_d_valid_c5", d_valid2,  0);
    tick();
    tick();
    chk("col_i_valid_c7", if_valid2, 0);
    tick();
    chk("col_i_valid_c8", if_valid2, 1);
    chk("col_i_rdata_c8", if_rdata2, 32'h0050_0093);
    tick();
    if_req = 1'b0;
    chk("col_no_regrant_c9", mem_en2, 0);

    // Write; d_rdata must keep the earlier load value
    tick();
    d_wr = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF;
    #1;
    chk("wr_stall_w0", d_stall2, 1);
    tick();
    chk("wr_en_w1",    mem_en2,    1);
    chk("wr_we_w1",    mem_we2,    1);
    chk("wr_addr_w1",  mem_addr2,  32'h200);
    chk("wr_wdata_w1", mem_wdata2, 32'hDEAD_BEEF);
    tick();
    tick();
    chk("wr_valid_w3", d_valid2, 0);
    tick();
    chk("wr_valid_w4", d_valid2, 1);
    chk("wr_rdata_w4", d_rdata2, 32'hA5A5_0100);
    chk("wr_stall_w4", d_stall2, 0);
    tick();
    d_wr = 1'b0;
    chk("wr_no_regrant_w5", mem_en2, 0);

    // d_rd and d_wr together behave as one write
    tick();
    d_rd = 1'b1; d_wr = 1'b1; d_addr = 32'h204; d_wdata = 32'h1234_5678;
    n_en = 0; n_we = 0; seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (mem_en2) begin
        n_en++;
        if (mem_we2) n_we++;
      end
      if (d_valid2) begin
        seen = 1'b1;
        break;
      end
    end
    d_rd = 1'b0; d_wr = 1'b0;
    chk("rw_valid_seen", {31'd0, seen}, 1);
    chk("rw_access_cnt", n_en, 1);
    chk("rw_write_cnt",  n_we, 1);
    chk("rw_wdata",      mem_wdata2, 32'h1234_5678);
    chk("rw_rdata_held", d_rdata2,   32'hA5A5_0100);

    // Streak limit: fetch re-presented except in data-valid cycles
    do_reset();
    d_rd = 1'b1; d_addr = 32'h100; if_req = 1'b1; if_addr = 32'h40;
    prev_streak = u_dut2.streak_q;
    ng = 0; got_f = 8'd0;
    for (int c = 0; c < 200 && ng < 8; c++) begin
      tick();
      if (mem_en2) begin
        got_f[ng] = (mem_addr2 == 32'h40);
        if (mem_addr2 == 32'h40) chk("streak_before_fetch", {28'd0, prev_streak}, 3);
        ng++;
      end
      if_req = ~d_valid2;
      prev_streak = u_dut2.streak_q;
    end
    d_rd = 1'b0; if_req = 1'b0;
    chk("streak_grant_cnt", ng, 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("streak_order_%0d", i), {31'd0, got_f[i]}, {31'd0, (i == 3 || i == 7)});

    // Reset during BUSY_D at cnt=1
    do_reset();
    d_rd = 1'b1; d_addr = 32'h300;
    tick();
    chk("mr_en_c1", mem_en2, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mr_en_async",    mem_en2,   0);
    chk("mr_addr_async",  mem_addr2, 0);
    chk("mr_valid_async", d_valid2,  0);
    chk("mr_rdata_async", d_rdata2,  0);
    chk("mr_stall_async", d_stall2,  1);
    tick();
    tick();
    rst_n = 1'b1;
    chk("mr_valid_r0", d_valid2, 0);
    tick();
    chk("mr_en_r1",    mem_en2,   1);
    chk("mr_addr_r1",  mem_addr2, 32'h300);
    chk("mr_valid_r1", d_valid2,  0);
    tick();
    tick();
    chk("mr_valid_r3", d_valid2, 0);
    tick();
    chk("mr_valid_r4", d_valid2, 1);
    chk("mr_rdata_r4", d_rdata2, 32'hA5A5_0300);
    d_rd = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
